// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and load/store; data wins by default.
// Define ARB_STARVE_EN to add a counter that guarantees fetch progress after STARVE_LIMIT data grants.
module memory_arbiter #(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready
);

  // state   | meaning
  // IDLE    | arbitration cycle, RAM outputs zero
  // GRANT_I | fetch owns the RAM port
  // GRANT_D | load/store owns the RAM port
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t state, next_state;
  logic   dreq;
  logic   starve_grant;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (starve_grant) next_state = GRANT_I;
        else if (dreq)    next_state = GRANT_D;
        else if (iREN)    next_state = GRANT_I;
      end
      // Completion and abort both end the grant on the next edge.
      GRANT_I: if (!iREN || ramready) next_state = IDLE;
      GRANT_D: if (!dreq || ramready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      GRANT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      GRANT_D: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  assign iwait = iREN & ~((state == GRANT_I) & ramready);
  assign dwait = dreq & ~((state == GRANT_D) & ramready);
  assign iload = ramload;
  assign dload = ramload;

`ifdef ARB_STARVE_EN
  logic [CNT_W-1:0] starve_cnt;

  assign starve_grant = iREN && (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Counts data grants taken over a pending fetch; saturates at the limit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!iREN || next_state == GRANT_I)
        starve_cnt <= '0;
      else if (next_state == GRANT_D && starve_cnt < CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt   = '0;
  assign starve_grant = 1'b0;
`endif

endmodule
